// File: rtl/ltc2308_ctrl.sv
// ltc2308_ctrl - LTC2308 SAR ADC frame master: CONVST/SCK/SDI generation and SDO deserialisation.
// One accepted command = one frame; the returned result is tagged with the config sent in the previous frame.
module ltc2308_ctrl #(
  parameter int          CONVST_HI_CYC = 1,
  parameter int          CONV_WAIT_CYC = 82,
  parameter int          SCK_HALF_CYC  = 1,
  parameter int          CYCLE_CYC     = 100,
  parameter logic [5:0]  RESET_CFG     = 6'b100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_cfg,
  output logic        res_valid,
  output logic [11:0] res_data,
  output logic [5:0]  res_cfg,
  output logic        res_first,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo
);

  typedef enum logic [2:0] {S_HOLDOFF, S_IDLE, S_CONVST, S_WAIT, S_SHIFT} state_t;

  localparam int            CW        = 16;
  localparam logic [CW-1:0] CYC_M1    = CW'(CYCLE_CYC - 1);
  localparam logic [CW-1:0] HI_M1     = CW'(CONVST_HI_CYC - 1);
  localparam logic [CW-1:0] WAIT_M1   = CW'(CONV_WAIT_CYC - 1);
  localparam logic [CW-1:0] HALF_M1   = CW'(SCK_HALF_CYC - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] n_q, n_d;       // cycles since last CONVST rise (or since reset), saturating
  logic [CW-1:0] h_q, h_d;       // position inside the current SCK half-period
  logic [4:0]    e_q, e_d;       // index of the next SCK edge: even = rise, odd = fall
  logic [11:0]   shreg_q, shreg_d;
  logic [4:0]    sdi_sh_q, sdi_sh_d;
  logic [5:0]    cfg_cur_q, cfg_cur_d;
  logic [5:0]    cfg_prev_q, cfg_prev_d;
  logic          first_q, first_d;
  logic          convst_q, convst_d;
  logic          sck_q, sck_d;
  logic          sdi_q, sdi_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          res_valid_q, res_valid_d;
  logic [11:0]   res_data_q, res_data_d;
  logic [5:0]    res_cfg_q, res_cfg_d;
  logic          res_first_q, res_first_d;

  always_comb begin
    state_d     = state_q;
    n_d         = (n_q == '1) ? n_q : n_q + 1'b1;
    h_d         = h_q;
    e_d         = e_q;
    shreg_d     = shreg_q;
    sdi_sh_d    = sdi_sh_q;
    cfg_cur_d   = cfg_cur_q;
    cfg_prev_d  = cfg_prev_q;
    first_d     = first_q;
    convst_d    = convst_q;
    sck_d       = sck_q;
    sdi_d       = sdi_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_cfg_d   = res_cfg_q;
    res_first_d = res_first_q;

    case (state_q)
      S_HOLDOFF: begin
        if (n_q == CYC_M1) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cfg_cur_d = cmd_cfg;
          sdi_sh_d  = cmd_cfg[4:0];
          sdi_d     = cmd_cfg[5];
          convst_d  = 1'b1;
          n_d       = '0;
          state_d   = S_CONVST;
        end
      end
      S_CONVST: begin
        if (n_q == HI_M1) begin
          convst_d = 1'b0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (n_q == WAIT_M1) begin
          sck_d   = 1'b1;
          shreg_d = {shreg_q[10:0], adc_sdo};
          h_d     = '0;
          e_d     = 5'd1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (h_q == HALF_M1) begin
          h_d = '0;
          e_d = e_q + 5'd1;
          if (!e_q[0]) begin
            sck_d   = 1'b1;
            shreg_d = {shreg_q[10:0], adc_sdo};
          end else begin
            // Shifting zeros in behind the config leaves SDI low after pulse 5.
            sck_d    = 1'b0;
            sdi_d    = sdi_sh_q[4];
            sdi_sh_d = {sdi_sh_q[3:0], 1'b0};
            if (e_q == 5'd23) begin
              res_valid_d = 1'b1;
              res_data_d  = shreg_q;
              res_cfg_d   = cfg_prev_q;
              res_first_d = first_q;
              cfg_prev_d  = cfg_cur_q;
              first_d     = 1'b0;
              state_d     = S_IDLE;
            end
          end
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      default: state_d = S_HOLDOFF;
    endcase

    cmd_ready_d = (state_d == S_IDLE) && (n_d >= CYC_M1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_HOLDOFF;
      n_q         <= '0;
      h_q         <= '0;
      e_q         <= '0;
      shreg_q     <= '0;
      sdi_sh_q    <= '0;
      cfg_cur_q   <= RESET_CFG;
      cfg_prev_q  <= RESET_CFG;
      first_q     <= 1'b1;
      convst_q    <= 1'b0;
      sck_q       <= 1'b0;
      sdi_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_cfg_q   <= RESET_CFG;
      res_first_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      h_q         <= h_d;
      e_q         <= e_d;
      shreg_q     <= shreg_d;
      sdi_sh_q    <= sdi_sh_d;
      cfg_cur_q   <= cfg_cur_d;
      cfg_prev_q  <= cfg_prev_d;
      first_q     <= first_d;
      convst_q    <= convst_d;
      sck_q       <= sck_d;
      sdi_q       <= sdi_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_cfg_q   <= res_cfg_d;
      res_first_q <= res_first_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_cfg    = res_cfg_q;
  assign res_first  = res_first_q;
  assign adc_convst = convst_q;
  assign adc_sck    = sck_q;
  assign adc_sdi    = sdi_q;

endmodule

// File: tb/tb_ltc2308_ctrl.sv
// tb/tb_ltc2308_ctrl.sv - scoreboard bench for ltc2308_ctrl with a cycle-based LTC2308 model.
`timescale 1ns/1ps
module tb_ltc2308_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_cfg = 6'b0;
  logic        res_valid;
  logic [11:0] res_data;
  logic [5:0]  res_cfg;
  logic        res_first;
  logic        adc_convst, adc_sck, adc_sdi;
  logic        adc_sdo = 1'b0;

  ltc2308_ctrl dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_cfg(cmd_cfg),
    .res_valid(res_valid), .res_data(res_data), .res_cfg(res_cfg), .res_first(res_first),
    .adc_convst(adc_convst), .adc_sck(adc_sck), .adc_sdi(adc_sdi), .adc_sdo(adc_sdo)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int min);
    n_cmp++;
    if (act < min) begin
      n_err++;
      $display("FAIL %s: got %0d cycles need >= %0d (cycle %0d)", name, act, min, cyc);
    end
  endtask

  // LTC2308 model: 50 MHz clock, so 2 us = 100 cycles, 1.6 us = 80 cycles
  logic [11:0] ch [8];
  logic [5:0]  m_pend = 6'b100000;
  logic [5:0]  m_sh = 6'b0;
  logic [5:0]  m_sdi_word = 6'b0;
  logic [11:0] m_data = 12'b0;
  logic        m_convst_p = 1'b0, m_sck_p = 1'b0, m_have_rise = 1'b0;
  int          m_rise = 0, m_last_r = 0, m_last_f = 0, m_nrise = 0, m_nfall = 0, m_idx = 0;
  int          rise_q[$];

  always @(negedge clk) begin
    if (adc_convst && !m_convst_p) begin
      if (m_have_rise) chk_ge("tCYC", cyc - m_rise, 100);
      if (m_nfall > 0) chk_ge("tWCLK", cyc - m_last_f, 1);
      chk("sck_low_at_convst", int'(adc_sck), 0);
      m_have_rise = 1'b1;
      m_rise      = cyc;
      rise_q.push_back(cyc);
      m_data      = ch[{m_pend[3:2], m_pend[4]}];
      m_idx       = 0;
      m_nrise     = 0;
      m_nfall     = 0;
      adc_sdo     = m_data[11];
    end
    if (!adc_convst && m_convst_p) chk_ge("convst_high", cyc - m_rise, 1);
    if (adc_sck && !m_sck_p) begin
      if (m_nrise == 0) chk_ge("tCONV", cyc - m_rise, 80);
      else begin
        chk_ge("sck_period", cyc - m_last_r, 2);
        chk_ge("sck_low", cyc - m_last_f, 1);
      end
      if (m_nrise < 6) begin
        m_sh = {m_sh[4:0], adc_sdi};
        if (m_nrise == 5) begin
          m_pend     = m_sh;
          m_sdi_word = m_sh;
        end
      end
      m_last_r = cyc;
      m_nrise++;
    end
    if (!adc_sck && m_sck_p) begin
      chk_ge("sck_high", cyc - m_last_r, 1);
      m_last_f = cyc;
      m_nfall++;
      m_idx++;
      adc_sdo = (m_idx < 12) ? m_data[11 - m_idx] : 1'b0;
    end
    m_convst_p = adc_convst;
    m_sck_p    = adc_sck;
  end

  typedef struct {
    logic [11:0] d;
    logic [5:0]  c;
    logic        f;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: every res_valid cycle must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_res: got res_valid with data 0x%0h, required no result (cycle %0d)", res_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_data", int'(res_data), int'(e.d));
        chk("res_cfg", int'(res_cfg), int'(e.c));
        chk("res_first", int'(res_first), int'(e.f));
        chk("res_latency", cyc - m_rise, 105);
      end
    end
  end

  task automatic do_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_convst", int'(adc_convst), 0);
    chk("rst_sck", int'(adc_sck), 0);
    chk("rst_sdi", int'(adc_sdi), 0);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_res_cfg", int'(res_cfg), 6'b100000);
    chk("rst_res_first", int'(res_first), 1);
    reset = 1'b0;
    begin
      int r;
      int w;
      r = cyc;
      w = 0;
      while (cmd_ready !== 1'b1 && w < 300) begin
        @(negedge clk);
        w++;
      end
      chk("ready_delay", cyc - r, 100);
    end
  endtask

  task automatic issue(input logic [5:0] cfg, input logic [11:0] ed, input logic [5:0] ec,
                       input logic ef, input bit push, input bit keep);
    int w;
    w         = 0;
    cmd_cfg   = cfg;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (cmd_ready !== 1'b1) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
    end else begin
      if (push) exp_q.push_back('{d: ed, c: ec, f: ef});
      @(negedge clk);
      if (!keep) cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("drain_pending", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    logic [11:0] walk [3];
    walk[0] = 12'h001;
    walk[1] = 12'h800;
    walk[2] = 12'hFFF;
    for (int i = 0; i < 8; i++) ch[i] = 12'h000;

    do_reset();

    ch[0] = 12'hA5C;
    issue(6'b100010, 12'hA5C, 6'b100000, 1'b1, 1'b1, 1'b0);
    drain();
    chk("sdi_word", int'(m_sdi_word), 6'b100010);

    do_reset();
    ch[0] = 12'h123;
    ch[2] = 12'h456;
    issue(6'b100000, 12'h123, 6'b100000, 1'b1, 1'b1, 1'b0);
    issue(6'b100100, 12'h123, 6'b100000, 1'b0, 1'b1, 1'b0);
    issue(6'b100100, 12'h456, 6'b100100, 1'b0, 1'b1, 1'b0);
    drain();

    issue(6'b100000, 12'h456, 6'b100100, 1'b0, 1'b1, 1'b0);
    drain();
    for (int i = 0; i < 3; i++) begin
      ch[0] = walk[i];
      issue(6'b100000, walk[i], 6'b100000, 1'b0, 1'b1, 1'b0);
      drain();
    end

    ch[0] = 12'h3C3;
    rise_q.delete();
    for (int i = 0; i < 5; i++)
      issue(6'b100000, 12'h3C3, 6'b100000, 1'b0, 1'b1, i < 4);
    drain();
    chk("b2b_frames", rise_q.size(), 5);
    for (int i = 0; i + 1 < rise_q.size(); i++)
      chk("b2b_spacing", rise_q[i+1] - rise_q[i], 106);

    ch[0] = 12'h5A5;
    issue(6'b100000, 12'h000, 6'b100000, 1'b0, 1'b0, 1'b0);
    begin
      int  nr;
      int  w;
      logic sp;
      nr = 0;
      w  = 0;
      sp = adc_sck;
      while (nr < 5 && w < 300) begin
        @(negedge clk);
        w++;
        if (adc_sck && !sp) nr++;
        sp = adc_sck;
      end
      chk("reach_pulse4", nr, 5);
    end
    do_reset();
    issue(6'b100000, 12'h5A5, 6'b100000, 1'b1, 1'b1, 1'b0);
    drain();

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ltc2308_ctrl.md
# ltc2308_ctrl

Synthesizable master for the LTC2308 8-channel 12-bit SAR ADC on the DE10-Nano. It drives CONVST, SCK and SDI and deserialises SDO. Each accepted command runs one conversion frame, which shifts the 6-bit config word for the next conversion into the ADC. The frame also returns the 12-bit result of the current conversion, tagged with the config that produced it. The block sits between the `adc_*` board pins (the LTC2308 behavioural model in simulation) and user logic or the JTAG register bank.

## Interface
Parameters (all timing in clk cycles; defaults assume 50 MHz clk):
- CONVST_HI_CYC, 1: CONVST high width. Must satisfy 20–40 ns.
- CONV_WAIT_CYC, 82: cycles from CONVST rise to first SCK rise. Must be ≥ tCONV max of 1.6 µs.
- SCK_HALF_CYC, 1: SCK high time and SCK low time. Must give ≥10 ns per half and a period ≥25 ns.
- CYCLE_CYC, 100: minimum cycles between CONVST rises. Must be ≥ tCYC of 2 µs.
- RESET_CFG, 6'b100000: config the ADC holds at power-up.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  request a conversion frame.
- cmd_ready  out  1  block can accept a command.
- cmd_cfg  in  6  config word {S/D, O/S, S1, S0, UNI, SLP} shifted out in this frame.
- res_valid  out  1  one-cycle pulse; res_* are valid.
- res_data  out  12  conversion result, MSB first on SDO.
- res_cfg  out  6  config that produced res_data, i.e. the config sent in the previous frame.
- res_first  out  1  res_cfg is RESET_CFG by assumption; this is the first result after reset.
- adc_convst  out  1  CONVST pin.
- adc_sck  out  1  SCK pin.
- adc_sdi  out  1  SDI pin.
- adc_sdo  in  1  SDO pin.

## Operation
- The FSM has five states: HOLDOFF, IDLE, CONVST, WAIT, SHIFT.
- **Reset** forces the following on the same edge:
  - adc_convst=0, adc_sck=0, adc_sdi=0
  - cmd_ready=0, res_valid=0, res_data=0
  - res_cfg=RESET_CFG, res_first=1
  - state=HOLDOFF, with the cycle counter cleared.
- **HOLDOFF** waits CYCLE_CYC cycles, then enters IDLE. This protects tCYC when reset arrives mid-frame.
- **IDLE** drives cmd_ready=1, but only once CYCLE_CYC cycles have elapsed since the last CONVST rise. On cmd_valid&&cmd_ready:
  - latch cmd_cfg into cfg_cur
  - set adc_convst=1
  - set adc_sdi=cmd_cfg[5]
  - set cmd_ready=0
  - go to CONVST.
- **CONVST** holds adc_convst for CONVST_HI_CYC cycles, then drives it 0 and moves to WAIT.
- **WAIT** runs until CONV_WAIT_CYC cycles after the CONVST rise, then moves to SHIFT.
- **SHIFT** issues exactly 12 SCK pulses, each SCK_HALF_CYC high and SCK_HALF_CYC low.
  - On the edge that raises SCK, sample adc_sdo into bit position 11-k (k = pulse index 0..11).
  - On the edge that lowers SCK after pulse k<5, drive adc_sdi=cfg_cur[4-k]. After pulse 5, drive adc_sdi=0.
- **End of frame**: on the edge that lowers SCK after pulse 11:
  - res_valid=1 for one cycle
  - res_data = the 12 samples
  - res_cfg = cfg_prev, res_first = first-frame flag
  - then cfg_prev←cfg_cur, clear the first-frame flag, go to IDLE.
- The SLP bit and the UNI bit are passed through unchanged. The block does not interpret them.
- cmd_cfg is don't-care outside the accept cycle.

## Timing
- Let t0 be the accept edge, where adc_convst rises.
- adc_convst falls at t0+CONVST_HI_CYC.
- SCK rise k occurs at t0+CONV_WAIT_CYC+2k·SCK_HALF_CYC. SCK fall k occurs one half-period later.
- res_valid is asserted at t0+CONV_WAIT_CYC+23·SCK_HALF_CYC. With defaults this is t0+105.
- The earliest next accept edge is max(t0+CYCLE_CYC, res_valid edge+1). With defaults this is t0+106, giving ≈471 kS/s.
- SDI changes only on SCK-fall edges, or at t0 for bit 5. This gives ≥1 half-period of setup and meets the 2.5 ns hold.
- SDO is sampled one full half-period after each SCK fall, which exceeds tdDO max of 12.5 ns.
- No SCK edge occurs before tCONV max. CONVST stays low until ≥1 cycle after the last SCK fall.
- cmd_valid held continuously yields back-to-back frames at the minimum period.
- Reset asserted mid-frame aborts the frame with no res_valid pulse. The next result has res_first=1.

## Test plan
- **Reset**: check all outputs at their reset values. cmd_ready must stay 0 for CYCLE_CYC cycles after reset deasserts, then go 1.
- **Single frame**:
  - Stimulus: CH0=12'hA5C, cmd_cfg=6'b100010.
  - Expect res_valid at t0+105 with res_data=12'hA5C, res_cfg=6'b100000, res_first=1.
  - The SDI bit sequence captured by the model must be 100010.
- **Config tagging**:
  - Stimulus: CH0=12'h123, CH2=12'h456. Send frames with cfg 100000, 100100, 100100.
  - Expect results 123 (res_cfg 100000, res_first=1), then 123 (res_cfg 100000, res_first=0), then 456 (res_cfg 100100, res_first=0).
- **Back-to-back**: hold cmd_valid=1 for 5 frames. CONVST rises must be spaced exactly 106 cycles apart. The model's tCYC/tCONV/tWCLK checks must not fire.
- **Walking ones**: sweep CH0 through 12'h001, 12'h800 and 12'hFFF. Each res_data must equal the input exactly, catching MSB/LSB and bit-order errors.
- **Mid-frame reset**: assert reset during SHIFT pulse 4. Expect no res_valid pulse and no model timing violation. The next frame returns correct data with res_first=1.
